// File: rtl/reg_writeback_ctrl_if.sv
// Bundle of the writeback controller's source, scoreboard and register-file ports.
// The master side feeds results and issue info; the slave side is the controller.
interface reg_writeback_ctrl_if #(
  parameter int AW = 2
);
  logic          AluValid;
  logic [4:0]    AluDest;
  logic [31:0]   AluData;
  logic          LoadValid;
  logic          LoadReady;
  logic [4:0]    LoadDest;
  logic [31:0]   LoadData;
  logic          IssueValid;
  logic [4:0]    IssueDest;
  logic [31:0]   PendingMask;
  logic          RegWrite;
  logic [4:0]    WriteReg;
  logic [31:0]   WriteData;
  logic [AW:0]   FifoCount;

  modport master (
    output AluValid, AluDest, AluData,
    output LoadValid, LoadDest, LoadData,
    output IssueValid, IssueDest,
    input  LoadReady, PendingMask, RegWrite, WriteReg, WriteData, FifoCount
  );

  modport slave (
    input  AluValid, AluDest, AluData,
    input  LoadValid, LoadDest, LoadData,
    input  IssueValid, IssueDest,
    output LoadReady, PendingMask, RegWrite, WriteReg, WriteData, FifoCount
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Single write port arbiter for the register file: ALU first, then queued loads,
// then a direct load bypass; keeps a pending-load scoreboard for RAW stalls.
module reg_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  reg_writeback_ctrl_if.slave bus
);

  typedef enum logic [1:0] {SEL_NONE, SEL_ALU, SEL_FIFO, SEL_BYPASS} sel_e;

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE_C = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE_C = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] rd_ptr_r, wr_ptr_r;
  logic [AW:0]   count_r;
  logic [4:0]    fifo_dest_r [DEPTH];
  logic [31:0]   fifo_data_r [DEPTH];
  logic [31:0]   pending_r, pending_nxt_s;
  logic          reg_write_r;
  logic [4:0]    write_reg_r;
  logic [31:0]   write_data_r;

  logic          ready_s, fire_s, push_s, pop_s;
  sel_e          sel_s;
  logic [4:0]    sel_dest_s;
  logic [31:0]   sel_data_s;

  // Ready depends only on occupancy so upstream never sees an input-to-ready loop.
  assign ready_s         = (count_r < DEPTH_C);
  assign bus.LoadReady   = ready_s;
  assign bus.FifoCount   = count_r;
  assign bus.PendingMask = pending_r;
  assign bus.RegWrite    = reg_write_r;
  assign bus.WriteReg    = write_reg_r;
  assign bus.WriteData   = write_data_r;

  // Fixed-priority source selection, FIFO push/pop decisions and next scoreboard.
  always_comb begin
    fire_s     = bus.LoadValid & ready_s;
    sel_s      = SEL_NONE;
    sel_dest_s = 5'd0;
    sel_data_s = 32'd0;
    if (bus.AluValid) begin
      sel_s      = SEL_ALU;
      sel_dest_s = bus.AluDest;
      sel_data_s = bus.AluData;
    end else if (count_r != {(AW+1){1'b0}}) begin
      sel_s      = SEL_FIFO;
      sel_dest_s = fifo_dest_r[rd_ptr_r];
      sel_data_s = fifo_data_r[rd_ptr_r];
    end else if (fire_s) begin
      sel_s      = SEL_BYPASS;
      sel_dest_s = bus.LoadDest;
      sel_data_s = bus.LoadData;
    end else begin
      sel_s      = SEL_NONE;
    end
    pop_s  = (sel_s == SEL_FIFO);
    push_s = fire_s & (sel_s != SEL_BYPASS);

    // Clear before set so a same-cycle reissue of the register stays pending.
    pending_nxt_s = pending_r;
    if ((sel_s == SEL_FIFO) || (sel_s == SEL_BYPASS)) begin
      pending_nxt_s[sel_dest_s] = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (bus.IssueValid && (bus.IssueDest != 5'd0)) begin
      pending_nxt_s[bus.IssueDest] = 1'b1;
    end else begin
      pending_nxt_s[0] = 1'b0;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Write-port registers, scoreboard and FIFO pointers/occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_r  <= 1'b0;
      write_reg_r  <= 5'd0;
      write_data_r <= 32'd0;
      pending_r    <= 32'd0;
      rd_ptr_r     <= {AW{1'b0}};
      wr_ptr_r     <= {AW{1'b0}};
      count_r      <= {(AW+1){1'b0}};
    end else begin
      case (sel_s)
        SEL_NONE: reg_write_r <= 1'b0;
        default: begin
          reg_write_r  <= (sel_dest_s != 5'd0);
          write_reg_r  <= sel_dest_s;
          write_data_r <= sel_data_s;
        end
      endcase
      pending_r <= pending_nxt_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_dest_r[wr_ptr_r] <= bus.LoadDest;
      fifo_data_r[wr_ptr_r] <= bus.LoadData;
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Randomized and directed bench for reg_writeback_ctrl against a queue-based
// model of the arbitration, load queue and pending-load scoreboard.
module tb_reg_writeback_ctrl;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic rst_n;
  reg_writeback_ctrl_if #(.AW(AW)) bus ();

  reg_writeback_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  ent_t        mq[$];
  logic [31:0] mpend;
  logic        exp_we;
  logic [4:0]  exp_wreg;
  logic [31:0] exp_wdata;

  task automatic model_reset();
    mq.delete();
    mpend     = 32'd0;
    exp_we    = 1'b0;
    exp_wreg  = 5'd0;
    exp_wdata = 32'd0;
  endtask

  // Reference: one write per cycle, ALU > oldest queued load > new load.
  task automatic model_tick();
    bit   rdy, fire, sel, is_load;
    ent_t e, inc;
    rdy  = (mq.size() < DEPTH);
    fire = bus.LoadValid && rdy;
    inc.dest = bus.LoadDest;
    inc.data = bus.LoadData;
    sel = 0; is_load = 0; e = '0;
    if (bus.AluValid) begin
      sel = 1; e.dest = bus.AluDest; e.data = bus.AluData;
      if (fire) mq.push_back(inc);
    end else if (mq.size() > 0) begin
      sel = 1; is_load = 1; e = mq.pop_front();
      if (fire) mq.push_back(inc);
    end else if (fire) begin
      sel = 1; is_load = 1; e = inc;
    end
    if (sel) begin
      exp_we = (e.dest != 5'd0); exp_wreg = e.dest; exp_wdata = e.data;
    end else begin
      exp_we = 1'b0;
    end
    if (is_load) mpend[e.dest] = 1'b0;
    if (bus.IssueValid && bus.IssueDest != 5'd0) mpend[bus.IssueDest] = 1'b1;
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.AluValid = 1'b0;  bus.AluDest = 5'd0;  bus.AluData = 32'd0;
    bus.LoadValid = 1'b0; bus.LoadDest = 5'd0; bus.LoadData = 32'd0;
    bus.IssueValid = 1'b0; bus.IssueDest = 5'd0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      bus.AluValid = (i != 0); bus.AluDest = 5'd4; bus.AluData = $urandom;
      bus.LoadValid = 1'b1; bus.LoadDest = 5'(11 + i); bus.LoadData = $urandom;
      bus.IssueValid = 1'b1; bus.IssueDest = 5'(11 + i);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.RegWrite, bus.WriteReg, bus.WriteData, bus.PendingMask, bus.FifoCount} !== '0) begin
      failures++;
      $display("FAIL reset_async: got we=%0b reg=%0d data=%h pend=%h cnt=%0d, want all 0",
               bus.RegWrite, bus.WriteReg, bus.WriteData, bus.PendingMask, bus.FifoCount);
    end
    model_reset();
    idle_inputs();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.FifoCount !== 3'd0 || bus.RegWrite !== 1'b0) begin
        failures++;
        $display("FAIL reset_release: got cnt=%0d we=%0b, want cnt=0 we=0", bus.FifoCount, bus.RegWrite);
      end
    end
  endtask

  task automatic test_alu_only();
    bus.AluValid = 1'b1; bus.AluDest = 5'd5; bus.AluData = 32'hDEADBEEF;
    step();
    idle_inputs();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd5 || bus.WriteData !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL alu_only: got we=%0b reg=%0d data=%h, want 1/5/deadbeef",
               bus.RegWrite, bus.WriteReg, bus.WriteData);
    end
    step();
    checks++;
    if (bus.RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL alu_idle: got we=%0b, want 0", bus.RegWrite);
    end
  endtask

  task automatic test_conflict();
    bus.IssueValid = 1'b1; bus.IssueDest = 5'd7;
    step();
    idle_inputs();
    checks++;
    if (bus.PendingMask !== 32'h0000_0080) begin
      failures++;
      $display("FAIL issue_set: got pend=%h, want 00000080", bus.PendingMask);
    end
    bus.AluValid = 1'b1; bus.AluDest = 5'd3; bus.AluData = 32'h11;
    bus.LoadValid = 1'b1; bus.LoadDest = 5'd7; bus.LoadData = 32'h22;
    step();
    idle_inputs();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd3 || bus.WriteData !== 32'h11 ||
        bus.FifoCount !== 3'd1 || bus.PendingMask[7] !== 1'b1) begin
      failures++;
      $display("FAIL conflict_alu: got we=%0b reg=%0d data=%h cnt=%0d p7=%0b, want 1/3/11/1/1",
               bus.RegWrite, bus.WriteReg, bus.WriteData, bus.FifoCount, bus.PendingMask[7]);
    end
    step();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd7 || bus.WriteData !== 32'h22 ||
        bus.FifoCount !== 3'd0 || bus.PendingMask[7] !== 1'b0) begin
      failures++;
      $display("FAIL conflict_load: got we=%0b reg=%0d data=%h cnt=%0d p7=%0b, want 1/7/22/0/0",
               bus.RegWrite, bus.WriteReg, bus.WriteData, bus.FifoCount, bus.PendingMask[7]);
    end
  endtask

  task automatic test_fill();
    logic [31:0] ld[5];
    int idx = 0;
    int wcnt = 0;
    bit fire;
    for (int k = 0; k < 5; k++) ld[k] = $urandom;
    for (int cyc = 0; cyc < 20 && mq.size() < DEPTH; cyc++) begin
      bus.AluValid = 1'b1; bus.AluDest = 5'(20 + cyc % 10); bus.AluData = $urandom;
      bus.LoadValid = 1'b1; bus.LoadDest = 5'(10 + idx); bus.LoadData = ld[idx];
      fire = (mq.size() < DEPTH);
      step();
      if (fire) idx++;
    end
    checks++;
    if (bus.LoadReady !== 1'b0 || bus.FifoCount !== 3'd4) begin
      failures++;
      $display("FAIL fill_full: got ready=%0b cnt=%0d, want 0/4", bus.LoadReady, bus.FifoCount);
    end
    bus.AluDest = 5'd30; bus.AluData = 32'hA5A5_0001;
    bus.LoadDest = 5'(10 + idx); bus.LoadData = ld[idx];
    step();
    checks++;
    if (bus.WriteReg !== 5'd30 || bus.WriteData !== 32'hA5A5_0001 || bus.LoadReady !== 1'b0) begin
      failures++;
      $display("FAIL fill_alu_wins: got reg=%0d data=%h ready=%0b, want 30/a5a50001/0",
               bus.WriteReg, bus.WriteData, bus.LoadReady);
    end
    bus.AluValid = 1'b0;
    for (int cyc = 0; cyc < 20 && wcnt < 5; cyc++) begin
      bus.LoadValid = (idx < 5);
      bus.LoadDest = 5'(10 + (idx % 5)); bus.LoadData = ld[idx % 5];
      fire = bus.LoadValid && (mq.size() < DEPTH);
      step();
      if (fire) idx++;
      if (bus.RegWrite === 1'b1) begin
        checks++;
        if (bus.WriteReg !== 5'(10 + wcnt) || bus.WriteData !== ld[wcnt]) begin
          failures++;
          $display("FAIL fill_order%0d: got reg=%0d data=%h, want reg=%0d data=%h",
                   wcnt, bus.WriteReg, bus.WriteData, 10 + wcnt, ld[wcnt]);
        end
        wcnt++;
      end
    end
    idle_inputs();
    checks++;
    if (wcnt != 5 || bus.LoadReady !== 1'b1 || bus.FifoCount !== 3'd0) begin
      failures++;
      $display("FAIL fill_drain: got writes=%0d ready=%0b cnt=%0d, want 5/1/0",
               wcnt, bus.LoadReady, bus.FifoCount);
    end
  endtask

  task automatic test_dest_zero();
    bus.AluValid = 1'b1; bus.AluDest = 5'd0; bus.AluData = 32'hFFFFFFFF;
    step();
    idle_inputs();
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.WriteReg !== 5'd0 || bus.WriteData !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL dest0_alu: got we=%0b reg=%0d data=%h, want 0/0/ffffffff",
               bus.RegWrite, bus.WriteReg, bus.WriteData);
    end
    bus.IssueValid = 1'b1; bus.IssueDest = 5'd0;
    step();
    idle_inputs();
    checks++;
    if (bus.PendingMask !== mpend) begin
      failures++;
      $display("FAIL dest0_issue: got pend=%h, want %h", bus.PendingMask, mpend);
    end
  endtask

  task automatic test_set_clear_race();
    bus.IssueValid = 1'b1; bus.IssueDest = 5'd9;
    step();
    bus.LoadValid = 1'b1; bus.LoadDest = 5'd9; bus.LoadData = 32'h0909_0909;
    step();
    idle_inputs();
    checks++;
    if (bus.PendingMask[9] !== 1'b1 || bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd9) begin
      failures++;
      $display("FAIL race_set_wins: got p9=%0b we=%0b reg=%0d, want 1/1/9",
               bus.PendingMask[9], bus.RegWrite, bus.WriteReg);
    end
    bus.LoadValid = 1'b1; bus.LoadDest = 5'd9; bus.LoadData = 32'h0909_0A0A;
    step();
    idle_inputs();
    checks++;
    if (bus.PendingMask[9] !== 1'b0) begin
      failures++;
      $display("FAIL race_clear: got p9=%0b, want 0", bus.PendingMask[9]);
    end
  endtask

  task automatic test_random();
    int unsigned d;
    for (int cyc = 0; cyc < 400; cyc++) begin
      d = $urandom_range(0, 31);
      bus.AluValid = ($urandom_range(0, 2) == 0) && !mpend[d];
      bus.AluDest = 5'(d); bus.AluData = $urandom;
      bus.LoadValid = ($urandom_range(0, 1) == 1);
      bus.LoadDest = 5'($urandom_range(0, 31)); bus.LoadData = $urandom;
      bus.IssueValid = ($urandom_range(0, 3) == 0);
      bus.IssueDest = 5'($urandom_range(0, 31));
      checks++;
      if (bus.LoadReady !== (mq.size() < DEPTH)) begin
        failures++;
        $display("FAIL rand_ready cyc%0d: got %0b, want %0b", cyc, bus.LoadReady, mq.size() < DEPTH);
      end
      step();
      checks++;
      if (bus.RegWrite !== exp_we || (exp_we && (bus.WriteReg !== exp_wreg || bus.WriteData !== exp_wdata)) ||
          bus.FifoCount !== 3'(mq.size()) || bus.PendingMask !== mpend) begin
        failures++;
        $display("FAIL rand_out cyc%0d: got we=%0b reg=%0d data=%h cnt=%0d pend=%h, want we=%0b reg=%0d data=%h cnt=%0d pend=%h",
                 cyc, bus.RegWrite, bus.WriteReg, bus.WriteData, bus.FifoCount, bus.PendingMask,
                 exp_we, exp_wreg, exp_wdata, mq.size(), mpend);
      end
    end
    idle_inputs();
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_alu_only();
    test_conflict();
    test_fill();
    test_dest_zero();
    test_set_clear_race();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
